// File: rtl/programable_n_bit_arith_sequencer.sv
// WIDTH-bit arithmetic sequencer: ADD/SUB in one step, shift-add MUL and restoring DIV over WIDTH steps.
// Optional JAM abort input is enabled by defining JAM_ABORT_EN.
module programable_n_bit_arith_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             SYSTEM_CLK,
    input  logic             RESET,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA_IN_A,
    input  logic [WIDTH-1:0] DATA_IN_B,
    input  logic             GO_BAR,
`ifdef JAM_ABORT_EN
    input  logic             JAM,
`endif
    output logic [WIDTH-1:0] DATA_OUT,
    output logic [WIDTH-1:0] DATA_OUT_HI,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR
);
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_ITER, S_FINISH} state_t;

    state_t           r_state, w_next;
    logic             r_armed;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic [WIDTH-1:0] r_dout, r_dout_hi;
    logic             r_carry, r_busy, r_done, r_error;

    logic             w_jam, w_abort, w_accept, w_iter_start;
    logic [WIDTH:0]   w_add, w_sub, w_msum, w_madd, w_dshift, w_ddiff;
    logic             w_dge;

`ifdef JAM_ABORT_EN
    assign w_jam = JAM;
`else
    assign w_jam = 1'b0;
`endif

    assign w_abort      = w_jam && (r_state != S_IDLE);
    assign w_accept     = (r_state == S_IDLE) && !GO_BAR && r_armed;
    assign w_iter_start = (OPCODE == OP_MUL) || ((OPCODE == OP_DIV) && (DATA_IN_B != '0));

    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};

    // Multiply: {r_hi,r_lo} holds partial product over the multiplier, shifted right each step.
    assign w_msum = {1'b0, r_hi} + {1'b0, r_b};
    assign w_madd = r_lo[0] ? w_msum : {1'b0, r_hi};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend bits out and quotient bits in.
    assign w_dshift = {r_hi, r_lo[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_b};
    assign w_dge    = (w_dshift >= {1'b0, r_b});

    always_ff @(posedge SYSTEM_CLK) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_iter_start ? S_ITER : S_EXEC;
            S_EXEC:   w_next = S_FINISH;
            S_ITER:   if (r_cnt == '0) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (!RESET) begin
            r_armed   <= 1'b1;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dout    <= '0;
            r_dout_hi <= '0;
            r_carry   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            if (GO_BAR) r_armed <= 1'b1;
            if (w_abort) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (w_accept) begin
                        r_armed <= 1'b0;
                        r_op    <= OPCODE;
                        r_a     <= DATA_IN_A;
                        r_b     <= DATA_IN_B;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_hi    <= '0;
                        r_lo    <= DATA_IN_A;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                    S_EXEC: begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        case (r_op)
                            OP_ADD: begin
                                r_dout    <= w_add[WIDTH-1:0];
                                r_dout_hi <= '0;
                                r_carry   <= w_add[WIDTH];
                            end
                            OP_SUB: begin
                                r_dout    <= w_sub[WIDTH-1:0];
                                r_dout_hi <= '0;
                                r_carry   <= w_sub[WIDTH];
                            end
                            OP_DIV: begin
                                r_dout    <= '1;
                                r_dout_hi <= r_a;
                                r_carry   <= 1'b0;
                                r_error   <= 1'b1;
                            end
                            OP_NOP:  ;
                            default: r_error <= 1'b1;
                        endcase
                    end
                    S_ITER: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_op == OP_MUL) begin
                                r_hi <= w_madd[WIDTH:1];
                                r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
                            end else begin
                                r_hi <= w_dge ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
                                r_lo <= {r_lo[WIDTH-2:0], w_dge};
                            end
                        end else begin
                            r_dout    <= r_lo;
                            r_dout_hi <= r_hi;
                            r_carry   <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                    S_FINISH: r_done <= 1'b0;
                    default:  ;
                endcase
            end
        end
    end

    assign DATA_OUT    = r_dout;
    assign DATA_OUT_HI = r_dout_hi;
    assign CARRY       = r_carry;
    assign BUSY        = r_busy;
    assign DONE        = r_done;
    assign ERROR       = r_error;
endmodule

// File: tb/tb_programable_n_bit_arith_sequencer.sv
// Directed bench: 8-bit vector table plus reset, GO_BAR hold and 16-bit multiply (and JAM) sequences.
module tb_programable_n_bit_arith_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op8;
    logic [7:0] a8, b8, lo8, hi8;
    logic       go8, c8, busy8, done8, err8;
    logic [3:0]  op16;
    logic [15:0] a16, b16, lo16, hi16;
    logic        go16, c16, busy16, done16, err16;
`ifdef JAM_ABORT_EN
    logic jam8 = 1'b0;
    logic jam16 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    programable_n_bit_arith_sequencer #(.WIDTH(8), .CNT_W(6)) u_dut8 (
        .SYSTEM_CLK(clk), .RESET(rst_n), .OPCODE(op8), .DATA_IN_A(a8), .DATA_IN_B(b8), .GO_BAR(go8),
`ifdef JAM_ABORT_EN
        .JAM(jam8),
`endif
        .DATA_OUT(lo8), .DATA_OUT_HI(hi8), .CARRY(c8), .BUSY(busy8), .DONE(done8), .ERROR(err8)
    );

    programable_n_bit_arith_sequencer #(.WIDTH(16), .CNT_W(6)) u_dut16 (
        .SYSTEM_CLK(clk), .RESET(rst_n), .OPCODE(op16), .DATA_IN_A(a16), .DATA_IN_B(b16), .GO_BAR(go16),
`ifdef JAM_ABORT_EN
        .JAM(jam16),
`endif
        .DATA_OUT(lo16), .DATA_OUT_HI(hi16), .CARRY(c16), .BUSY(busy16), .DONE(done16), .ERROR(err16)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, lo, hi;
        logic       c, e;
        int         lat;
    } vec_t;
    vec_t tv[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one 8-bit operation, release GO_BAR after acceptance, return cycles to DONE (99 on timeout).
    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        op8 = op; a8 = a; b8 = b; go8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b1;
        op8 = 4'hA; a8 = 8'h5A; b8 = 8'hA5;
        chk("busy_after_accept", busy8, 1'b1);
        lat = 99;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, pulses;
        tv[0]  = '{4'h3, 8'h14, 8'h23, 8'h37, 8'h00, 1'b0, 1'b0, 1};
        tv[1]  = '{4'h3, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1};
        tv[2]  = '{4'h7, 8'h81, 8'h41, 8'h40, 8'h00, 1'b0, 1'b0, 1};
        tv[3]  = '{4'h7, 8'h41, 8'h81, 8'hC0, 8'h00, 1'b1, 1'b0, 1};
        tv[4]  = '{4'hC, 8'h05, 8'h07, 8'h23, 8'h00, 1'b0, 1'b0, 9};
        tv[5]  = '{4'hC, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 9};
        tv[6]  = '{4'hC, 8'h80, 8'h02, 8'h00, 8'h01, 1'b0, 1'b0, 9};
        tv[7]  = '{4'hD, 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9};
        tv[8]  = '{4'hD, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b0, 1'b1, 1};
        tv[9]  = '{4'hF, 8'h12, 8'h34, 8'hFF, 8'h55, 1'b0, 1'b1, 1};
        tv[10] = '{4'h7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1};
        tv[11] = '{4'h3, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        tv[12] = '{4'h1, 8'h77, 8'h88, 8'h00, 8'h00, 1'b1, 1'b1, 1};
        tv[13] = '{4'h0, 8'h33, 8'h44, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        tv[14] = '{4'hD, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9};

        rst_n = 1'b0; go8 = 1'b1; go16 = 1'b1;
        op8 = '0; a8 = '0; b8 = '0; op16 = '0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_state", {lo8, hi8, c8, busy8, done8, err8}, '0);

        for (int i = 0; i < 15; i++) begin
            run8(tv[i].op, tv[i].a, tv[i].b, lat);
            chk($sformatf("row%0d latency", i), lat, tv[i].lat);
            chk($sformatf("row%0d data_out", i), lo8, tv[i].lo);
            chk($sformatf("row%0d data_out_hi", i), hi8, tv[i].hi);
            chk($sformatf("row%0d carry", i), c8, tv[i].c);
            chk($sformatf("row%0d error", i), err8, tv[i].e);
            chk($sformatf("row%0d busy_at_done", i), busy8, 1'b0);
            @(negedge clk);
            chk($sformatf("row%0d done_one_cycle", i), done8, 1'b0);
        end

        // GO_BAR held low through a whole multiply: exactly one DONE pulse.
        @(negedge clk);
        op8 = 4'hC; a8 = 8'h03; b8 = 8'h03; go8 = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("held_low_pulses", pulses, 1);
        chk("held_low_product", {hi8, lo8}, 16'h0009);
        go8 = 1'b1;

        // Reset during iteration 3 of a multiply.
        @(negedge clk);
        op8 = 4'hC; a8 = 8'hFF; b8 = 8'hFF; go8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_mul_reset_outputs", {lo8, hi8, c8, busy8, done8, err8}, '0);
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        chk("mid_mul_reset_idle", pulses, 0);
        run8(4'h3, 8'h01, 8'h02, lat);
        chk("post_reset_latency", lat, 1);
        chk("post_reset_sum", lo8, 8'h03);

        // 16-bit multiply.
        @(negedge clk);
        op16 = 4'hC; a16 = 16'h1234; b16 = 16'h0100; go16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        go16 = 1'b1;
        lat = 99;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done16) begin
                lat = k;
                break;
            end
        end
        chk("w16_latency", lat, 17);
        chk("w16_lo", lo16, 16'h3400);
        chk("w16_hi", hi16, 16'h0012);
        chk("w16_carry", c16, 1'b0);
        @(negedge clk);

`ifdef JAM_ABORT_EN
        // JAM at iteration 5 of a 16-bit multiply: abort with ERROR, results untouched.
        @(negedge clk);
        op16 = 4'hC; a16 = 16'hFFFF; b16 = 16'h0003; go16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        go16 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        jam16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        jam16 = 1'b0;
        chk("jam_busy", busy16, 1'b0);
        chk("jam_error", err16, 1'b1);
        chk("jam_lo_kept", lo16, 16'h3400);
        pulses = 0;
        repeat (25) begin
            @(posedge clk);
            @(negedge clk);
            if (done16) pulses++;
        end
        chk("jam_no_done", pulses, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
